// File: rtl/seg7_scan_ctrl.sv
// ============================================================================
// seg7_scan_ctrl
// ----------------------------------------------------------------------------
// Time-multiplexed scan controller for an N-digit common-anode 7-segment
// display. A single external combinational BCD-to-7-segment decoder is shared
// by all digits: this block presents one digit code on 'bcd' and registers
// the decoder's answer ('seg') into 'seg_out' while that digit is lit.
//
// Each digit slot is SCAN_DIV cycles long. The first BLANK_CYC cycles keep
// every anode off to suppress ghosting. The remaining cycles light the digit.
// A captured BCD word only becomes visible at a frame boundary, so a frame
// never shows a mix of old and new digits.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   en         : scan enable; low blanks the display and parks the scan
//   load       : one-cycle strobe that captures bcd_in
//   bcd_in     : packed BCD word; digit 0 is in [3:0]
//   bcd        : registered digit code that drives the shared decoder
//   seg        : decoder output for 'bcd' (combinational, external)
//   seg_out    : registered segment drive, active-high
//   an         : one-hot active-low digit enable
//   frame_tick : one-cycle pulse in the first cycle of each new frame
//
// Build option
//   SEG7_LZ_BLANK_EN : when defined, leading zeros are blanked. A digit k > 0
//                      whose nibble and every higher nibble are zero shows no
//                      segments, but its anode still pulses. Digit 0 always
//                      shows.
// ============================================================================
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int BLANK_CYC  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    output logic [3:0]              bcd,
    input  logic [6:0]              seg,
    output logic [6:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int DW = 4 * NUM_DIGITS;

    typedef enum logic {
        BLANK,
        SHOW
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [IW-1:0]   idx, idx_nxt;
    logic [DW-1:0]   shadow, shadow_nxt;
    logic [DW-1:0]   disp, disp_nxt;
    logic            pending, pending_nxt;
    logic            wrap;
    logic            hide;
    logic [3:0]      cur_nib;
    logic [3:0]      bcd_nxt;
    logic [6:0]      seg_nxt;
    logic [NUM_DIGITS-1:0] an_nxt;

    assign cur_nib = disp[{idx, 2'b00} +: 4];

`ifdef SEG7_LZ_BLANK_EN
    logic [NUM_DIGITS-1:0] lz;
    logic                  zero_run;

    // lz[k] is set when nibble k and all nibbles above it are zero. The scan
    // runs from the most significant digit downwards, so the first non-zero
    // nibble ends the run of leading zeros.
    always_comb begin
        lz       = '0;
        zero_run = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            lz[k]    = zero_run && (disp[4*k +: 4] == 4'd0);
            zero_run = lz[k];
        end
    end

    // A digit goes dark when its code is not a decimal digit, or when it is
    // a leading zero. Digit 0 is never treated as a leading zero.
    assign hide = (cur_nib > 4'd9) || ((idx != '0) && lz[idx]);
`else
    // A digit goes dark only when its code is not a decimal digit.
    // Whatever the decoder produces for such a code is ignored.
    assign hide = (cur_nib > 4'd9);
`endif

    // Next-state logic. The single counter runs 0..SCAN_DIV-1 across the
    // whole slot: the low BLANK_CYC counts are the blank gap and the rest are
    // the lit part. Loads always land in the shadow register. The displayed
    // word changes only on the frame wrap, and a load on that same cycle
    // bypasses the shadow register so the new word shows at once.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        idx_nxt     = idx;
        shadow_nxt  = shadow;
        disp_nxt    = disp;
        pending_nxt = pending;
        wrap        = 1'b0;

        if (load) begin
            shadow_nxt  = bcd_in;
            pending_nxt = 1'b1;
        end

        if (!en) begin
            state_nxt = BLANK;
            cnt_nxt   = '0;
        end else begin
            case (state)
                BLANK: begin
                    if (cnt == CW'(BLANK_CYC - 1)) begin
                        state_nxt = SHOW;
                    end
                    cnt_nxt = cnt + 1'b1;
                end
                SHOW: begin
                    if (cnt == CW'(SCAN_DIV - 1)) begin
                        state_nxt = BLANK;
                        cnt_nxt   = '0;
                        if (idx == IW'(NUM_DIGITS - 1)) begin
                            idx_nxt = '0;
                            wrap    = 1'b1;
                        end else begin
                            idx_nxt = idx + 1'b1;
                        end
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                default: begin
                    state_nxt = BLANK;
                    cnt_nxt   = '0;
                end
            endcase
        end

        if (wrap) begin
            disp_nxt    = load ? bcd_in : (pending ? shadow : disp);
            pending_nxt = 1'b0;
        end
    end

    // The output values are computed from the state being entered. This means
    // 'an' and 'seg_out' switch on the same edge as the state change. The
    // digit code is presented from the first blank cycle of its slot, so the
    // external decoder has settled before the digit lights. Entering SHOW
    // never changes idx or disp, so 'hide' (built from the current idx and
    // disp) describes the digit about to be lit.
    always_comb begin
        bcd_nxt = disp_nxt[{idx_nxt, 2'b00} +: 4];
        an_nxt  = '1;
        seg_nxt = '0;
        if (state_nxt == SHOW) begin
            an_nxt[idx_nxt] = 1'b0;
            if (!hide) begin
                seg_nxt = seg;
            end
        end
    end

    // Register the state and all outputs. frame_tick is high in the first
    // blank cycle of the new frame, which is the first cycle that shows the
    // newly committed display word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= BLANK;
            cnt        <= '0;
            idx        <= '0;
            shadow     <= '0;
            disp       <= '0;
            pending    <= 1'b0;
            bcd        <= '0;
            seg_out    <= '0;
            an         <= '1;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            shadow     <= shadow_nxt;
            disp       <= disp_nxt;
            pending    <= pending_nxt;
            bcd        <= bcd_nxt;
            seg_out    <= seg_nxt;
            an         <= an_nxt;
            frame_tick <= wrap;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// ============================================================================
// tb_seg7_scan_ctrl
// ----------------------------------------------------------------------------
// Directed testbench for seg7_scan_ctrl with NUM_DIGITS=4, SCAN_DIV=8 and
// BLANK_CYC=2. Each frame is 32 cycles. Inside a frame, digit k's blank gap
// is at cycle offsets 8k and 8k+1, and the digit is lit from offset 8k+2 to
// 8k+7. Offset 0 is the cycle in which frame_tick is high.
//
// The local decoder returns a visible "E" pattern for codes above 9. This
// makes a design that forwards it for invalid digits show up as a failure.
// ============================================================================
module tb_seg7_scan_ctrl;

    localparam int NUM_DIGITS = 4;
    localparam int SCAN_DIV   = 8;
    localparam int BLANK_CYC  = 2;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        load;
    logic [15:0] bcd_in;
    logic [3:0]  bcd;
    logic [6:0]  seg;
    logic [6:0]  seg_out;
    logic [3:0]  an;
    logic        frame_tick;

    int checkCount = 0;
    int errorCount = 0;

    seg7_scan_ctrl #(
        .NUM_DIGITS(NUM_DIGITS),
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .load      (load),
        .bcd_in    (bcd_in),
        .bcd       (bcd),
        .seg       (seg),
        .seg_out   (seg_out),
        .an        (an),
        .frame_tick(frame_tick)
    );

    // Clock with a 10-time-unit period. Inputs are driven and outputs are
    // sampled on the falling edge, away from the active edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared decoder model (gfedcba, active-high).
    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h79;
        endcase
    endfunction

    assign seg = decode(bcd);

    // Expected lit pattern for digit k of a display word: dark for an invalid
    // code and, when leading-zero blanking is built in, dark for a leading
    // zero above digit 0.
    function automatic logic [6:0] expSeg(input logic [15:0] v, input int k);
        logic [3:0]  nib;
        logic [15:0] upper;
        nib   = v[4*k +: 4];
        upper = v >> (4 * k);
        if (nib > 4'd9) return 7'h00;
`ifdef SEG7_LZ_BLANK_EN
        if (k > 0 && upper == 16'h0000) return 7'h00;
`else
        if (upper == 16'hFFFF) return 7'h00;
`endif
        return decode(nib);
    endfunction

    // Count one comparison and report it if it does not match.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)",
                     tag, observed, expected, $time);
        end
    endtask

    // Drive the load strobe and the BCD word.
    task automatic applyStimulus(input logic ld, input logic [15:0] val);
        load   = ld;
        bcd_in = val;
    endtask

    // Advance to the next falling edge where frame_tick is high.
    // Give up after a bounded number of cycles and count a timeout as a failure.
    task automatic waitFrameTick();
        int n;
        n = 0;
        while (!frame_tick && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (!frame_tick) checkOutput("frame_tick_timeout", 32'd0, 32'd1);
    endtask

    // Walk one whole frame from its frame_tick cycle and check every digit
    // slot against 'val'. Up to two loads can be injected at the given cycle
    // offsets (-1 means none). The task ends on the next frame_tick cycle.
    task automatic checkFrame(input logic [15:0] val,
                              input int c1, input logic [15:0] v1,
                              input int c2, input logic [15:0] v2);
        int         digit;
        int         off;
        logic [3:0] anExp;
        for (int c = 0; c < 32; c++) begin
            if (c == c1)      applyStimulus(1'b1, v1);
            else if (c == c2) applyStimulus(1'b1, v2);
            else              load = 1'b0;
            digit = c / 8;
            off   = c % 8;
            anExp = ~(4'b0001 << digit);
            if (off == 0) checkOutput("bcd", bcd, val[4*digit +: 4]);
            if (off == 1) checkOutput("an_blank", an, 4'hF);
            if (off == 1) checkOutput("seg_out_blank", seg_out, 7'h00);
            if (off == 2) checkOutput("an_show", an, anExp);
            if (off == 2) checkOutput("seg_out_show", seg_out, expSeg(val, digit));
            if (c == 1)   checkOutput("frame_tick_low", frame_tick, 1'b0);
            @(negedge clk);
        end
        load = 1'b0;
        checkOutput("frame_tick_period", frame_tick, 1'b1);
    endtask

    initial begin
        bit sawTick;

        rst_n  = 1'b0;
        en     = 1'b1;
        load   = 1'b0;
        bcd_in = 16'h0000;

        // Reset state.
        #12;
        checkOutput("reset_an", an, 4'hF);
        checkOutput("reset_seg_out", seg_out, 7'h00);
        checkOutput("reset_bcd", bcd, 4'h0);
        checkOutput("reset_frame_tick", frame_tick, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;

        // A mid-frame load appears only after the next wrap.
        @(negedge clk);
        applyStimulus(1'b1, 16'h1234);
        @(negedge clk);
        applyStimulus(1'b0, 16'h0000);
        waitFrameTick();
        checkFrame(16'h1234, -1, 16'h0, -1, 16'h0);

        // Two loads in one frame: the current frame is unchanged and the last load wins.
        checkFrame(16'h1234, 5, 16'h5678, 12, 16'h9012);

        // A load on the wrap cycle shows in the very next frame.
        checkFrame(16'h9012, 31, 16'h3456, -1, 16'h0);
        checkFrame(16'h3456, 3, 16'h12A4, -1, 16'h0);

        // Invalid digit 1 (code A): anode pulses, segments dark.
        checkFrame(16'h12A4, -1, 16'h0, -1, 16'h0);

        // Disable during the digit-2 lit slot, then resume at digit 2.
        repeat (19) @(negedge clk);
        checkOutput("en_pre_an", an, 4'b1011);
        en = 1'b0;
        @(negedge clk);
        checkOutput("en_off_an", an, 4'hF);
        checkOutput("en_off_seg_out", seg_out, 7'h00);
        checkOutput("en_off_frame_tick", frame_tick, 1'b0);
        repeat (4) @(negedge clk);
        checkOutput("en_held_an", an, 4'hF);
        en = 1'b1;
        @(negedge clk);
        checkOutput("en_restart_blank", an, 4'hF);
        @(negedge clk);
        checkOutput("en_resume_an", an, 4'b1011);
        checkOutput("en_resume_seg_out", seg_out, decode(4'd2));
        sawTick = 1'b0;
        for (int i = 0; i < 14; i++) begin
            if (frame_tick) sawTick = 1'b1;
            @(negedge clk);
        end
        checkOutput("en_no_early_tick", sawTick, 1'b0);
        checkOutput("en_resume_wrap_tick", frame_tick, 1'b1);
        checkOutput("en_resume_wrap_bcd", bcd, 4'h4);

        // Leading zeros (blanked only when the build option is enabled).
        checkFrame(16'h12A4, 0, 16'h0070, -1, 16'h0);
        checkFrame(16'h0070, -1, 16'h0, -1, 16'h0);

        // Asynchronous reset in the middle of the digit-0 lit slot.
        repeat (4) @(negedge clk);
        checkOutput("pre_reset_an", an, 4'b1110);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_an", an, 4'hF);
        checkOutput("async_reset_seg_out", seg_out, 7'h00);
        checkOutput("async_reset_frame_tick", frame_tick, 1'b0);
        checkOutput("async_reset_bcd", bcd, 4'h0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
